// File: rtl/pulse_train_generator.sv
// Programmable pulse-train source. After an accepted start it emits num_pulses
// rectangular pulses. Each pulse is high for max(high_len,1) cycles and then low
// for max(low_len,1) cycles. Every output is registered.
module pulse_train_generator #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned NUM_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [NUM_W-1:0] num_pulses,
  output logic             data_out,
  output logic             busy,
  output logic             done,
  output logic             rise_mark,
  output logic             fall_mark
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [NUM_W-1:0] NumOne = NUM_W'(1);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  state_e           state_q, state_d;
  // Cycles spent in the current phase, counting from 1 on phase entry.
  logic [CNT_W-1:0] phase_q, phase_d;
  // Index of the pulse in progress, counting from 1.
  logic [NUM_W-1:0] pulse_q, pulse_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] l_q, l_d;
  logic [NUM_W-1:0] n_q, n_d;
  logic             data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  logic             launch;
  logic [CNT_W-1:0] h_eff;
  logic [CNT_W-1:0] l_eff;

  // Zero lengths are promoted to one cycle.
  always_comb begin
    h_eff = (high_len == '0) ? CntOne : high_len;
    l_eff = (low_len == '0) ? CntOne : low_len;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pulse_d = pulse_q;
    h_d     = h_q;
    l_d     = l_q;
    n_d     = n_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    launch  = 1'b0;

    unique case (state_q)
      StIdle: begin
        launch = start & ~abort;
      end
      StHigh: begin
        if (abort) begin
          state_d = StIdle;
          data_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (phase_q == h_q) begin
          state_d = StLow;
          data_d  = 1'b0;
          fall_d  = 1'b1;
          phase_d = CntOne;
        end else begin
          phase_d = phase_q + CntOne;
        end
      end
      StLow: begin
        if (abort) begin
          state_d = StIdle;
          data_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (phase_q == l_q) begin
          if (pulse_q == n_q) begin
            // Train ends; a start sampled here chains the next train with no gap.
            state_d = StIdle;
            data_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            launch  = start;
          end else begin
            state_d = StHigh;
            data_d  = 1'b1;
            rise_d  = 1'b1;
            phase_d = CntOne;
            pulse_d = pulse_q + NumOne;
          end
        end else begin
          phase_d = phase_q + CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        data_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // Latch a new request; done set above survives so a chained train keeps it.
    if (launch) begin
      h_d     = h_eff;
      l_d     = l_eff;
      n_d     = num_pulses;
      phase_d = CntOne;
      pulse_d = NumOne;
      if (num_pulses != '0) begin
        state_d = StHigh;
        data_d  = 1'b1;
        busy_d  = 1'b1;
        rise_d  = 1'b1;
      end else begin
        state_d = StIdle;
        data_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  // State and registered outputs; reset kills any train immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      phase_q <= CntOne;
      pulse_q <= NumOne;
      h_q     <= CntOne;
      l_q     <= CntOne;
      n_q     <= '0;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pulse_q <= pulse_d;
      h_q     <= h_d;
      l_q     <= l_d;
      n_q     <= n_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign data_out  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rise_mark = rise_q;
  assign fall_mark = fall_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Bench for pulse_train_generator: directed vector table, hand-written corner
// sequences and randomized traffic against a timing-formula reference model.
module tb_pulse_train_generator;

  localparam int CW = 8;
  localparam int NW = 8;

  logic          clock;
  logic          reset;
  logic          start;
  logic          abort;
  logic [CW-1:0] high_len;
  logic [CW-1:0] low_len;
  logic [NW-1:0] num_pulses;
  logic          data_out;
  logic          busy;
  logic          done;
  logic          rise_mark;
  logic          fall_mark;

  pulse_train_generator #(
    .CNT_W(CW),
    .NUM_W(NW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .high_len  (high_len),
    .low_len   (low_len),
    .num_pulses(num_pulses),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done),
    .rise_mark (rise_mark),
    .fall_mark (fall_mark)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Downstream edge detector used for the loop-back check.
  logic prev_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= data_out;
  end
  wire edge_det = data_out & ~prev_q;

  int vectors;
  int miscompares;

  // Reference model: position inside the train, from which outputs follow by arithmetic.
  bit       m_active;
  int       m_t;
  int       m_h;
  int       m_l;
  int       m_n;
  bit [4:0] m_exp;  // {data, busy, done, rise, fall}

  function automatic bit [4:0] phase_out(int t, int h, int l);
    int r;
    r = t % (h + l);
    return {(r < h), 1'b1, 1'b0, (r == 0), (r == h)};
  endfunction

  task automatic model_accept(int hl, int ll, int np, bit keep_done);
    m_h = (hl == 0) ? 1 : hl;
    m_l = (ll == 0) ? 1 : ll;
    m_n = np;
    m_t = 0;
    if (np == 0) begin
      m_active = 1'b0;
      m_exp    = 5'b00100;
    end else begin
      m_active = 1'b1;
      m_exp    = phase_out(0, m_h, m_l) | (keep_done ? 5'b00100 : 5'b00000);
    end
  endtask

  // Advance the model by one clock edge given the inputs sampled at that edge.
  task automatic model_edge(bit s, bit a, int hl, int ll, int np);
    if (m_active && a) begin
      m_active = 1'b0;
      m_exp    = '0;
    end else if (m_active) begin
      m_t++;
      if (m_t == m_n * (m_h + m_l)) begin
        m_active = 1'b0;
        m_exp    = 5'b00100;
        if (s) model_accept(hl, ll, np, 1'b1);
      end else begin
        m_exp = phase_out(m_t, m_h, m_l);
      end
    end else if (s && !a) begin
      model_accept(hl, ll, np, 1'b0);
    end else begin
      m_exp = '0;
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_t      = 0;
    m_exp    = '0;
  endtask

  function automatic bit [4:0] dut_out();
    return {data_out, busy, done, rise_mark, fall_mark};
  endfunction

  task automatic check_vec(string name, bit [4:0] exp);
    vectors++;
    if (dut_out() !== exp) begin
      miscompares++;
      $display("FAIL %s: got {data,busy,done,rise,fall}=%b, expected %b at %0t",
               name, dut_out(), exp, $time);
    end
  endtask

  task automatic check_bit(string name, logic got, logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: model tracks the edge, outputs are compared 1 time unit later.
  task automatic step(string name);
    @(posedge clock);
    model_edge(start, abort, int'(high_len), int'(low_len), int'(num_pulses));
    #1;
    check_vec(name, m_exp);
  endtask

  task automatic drive(bit s, bit a, int hl, int ll, int np);
    start      = s;
    abort      = a;
    high_len   = CW'(hl);
    low_len    = CW'(ll);
    num_pulses = NW'(np);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    model_reset();
    check_vec("reset", 5'b00000);
    reset = 1'b0;
  endtask

  typedef struct {
    bit       s;
    bit       a;
    int       hl;
    int       ll;
    int       np;
    bit [4:0] exp;  // {data, busy, done, rise, fall}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit s, bit a, int hl, int ll, int np, bit [4:0] exp);
    vec_t v;
    v.s = s; v.a = a; v.hl = hl; v.ll = ll; v.np = np; v.exp = exp;
    return v;
  endfunction

  int edges;
  bit done_seen;

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    drive(0, 0, 0, 0, 0);

    // H=2, L=3, N=3: 11000 x3, done at cycle 15.
    tbl.push_back(mk(1, 0, 2, 3, 3, 5'b11010));
    tbl.push_back(mk(0, 0, 0, 0, 0, 5'b11000));
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(mk(0, 0, 0, 0, 0, 5'b01001));
      tbl.push_back(mk(0, 0, 0, 0, 0, 5'b01000));
      tbl.push_back(mk(0, 0, 0, 0, 0, 5'b01000));
      if (k < 2) begin
        tbl.push_back(mk(0, 0, 0, 0, 0, 5'b11010));
        tbl.push_back(mk(0, 0, 0, 0, 0, 5'b11000));
      end
    end
    tbl.push_back(mk(0, 0, 0, 0, 0, 5'b00100));
    tbl.push_back(mk(0, 0, 0, 0, 0, 5'b00000));
    // Zero lengths: H=L=0, N=2 -> 1,0,1,0 then done.
    tbl.push_back(mk(1, 0, 0, 0, 2, 5'b11010));
    tbl.push_back(mk(0, 0, 0, 0, 0, 5'b01001));
    tbl.push_back(mk(0, 0, 0, 0, 0, 5'b11010));
    tbl.push_back(mk(0, 0, 0, 0, 0, 5'b01001));
    tbl.push_back(mk(0, 0, 0, 0, 0, 5'b00100));
    // Zero count: done only, one cycle.
    tbl.push_back(mk(1, 0, 3, 3, 0, 5'b00100));
    tbl.push_back(mk(0, 0, 0, 0, 0, 5'b00000));
    // Abort in idle suppresses start.
    tbl.push_back(mk(1, 1, 2, 2, 2, 5'b00000));

    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].s, tbl[i].a, tbl[i].hl, tbl[i].ll, tbl[i].np);
      @(posedge clock);
      #1;
      check_vec($sformatf("table[%0d]", i), tbl[i].exp);
    end
    drive(0, 0, 0, 0, 0);

    // Ignored restart, then abort at cycle 6 of H=4,L=4,N=5.
    do_reset();
    drive(1, 0, 4, 4, 5);
    step("abort_seq_c0");
    drive(0, 0, 9, 9, 9);
    step("abort_seq_c1");
    drive(1, 0, 1, 1, 1);
    step("abort_seq_restart");
    drive(0, 0, 7, 7, 7);
    for (int c = 3; c <= 6; c++) step($sformatf("abort_seq_c%0d", c));
    check_bit("pre_abort_busy", busy, 1'b1);
    abort = 1'b1;
    step("abort_edge");
    check_bit("abort_data", data_out, 1'b0);
    check_bit("abort_busy", busy, 1'b0);
    abort = 1'b0;
    done_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step("post_abort");
      if (done) done_seen = 1'b1;
    end
    check_bit("abort_no_done", done_seen, 1'b0);

    // Abort during HIGH gives no fall_mark.
    drive(1, 0, 4, 1, 1);
    step("high_abort_start");
    drive(0, 1, 0, 0, 0);
    step("high_abort");
    check_bit("high_abort_fall", fall_mark, 1'b0);
    abort = 1'b0;

    // Back-to-back with start held high: new train starts in the done cycle.
    drive(1, 0, 1, 2, 2);
    for (int c = 0; c < 6; c++) step("b2b");
    step("b2b_join");
    check_bit("b2b_done", done, 1'b1);
    check_bit("b2b_data", data_out, 1'b1);
    check_bit("b2b_rise", rise_mark, 1'b1);
    start = 1'b0;
    for (int c = 0; c < 8; c++) step("b2b_tail");

    // Async reset in the middle of a high phase.
    drive(1, 0, 5, 1, 1);
    step("async_start");
    start = 1'b0;
    step("async_high");
    #2;
    reset = 1'b1;
    #1;
    check_bit("async_data", data_out, 1'b0);
    check_bit("async_busy", busy, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    check_vec("async_held", 5'b00000);

    // Loop-back: H=1,L=1,N=4 gives 4 detected edges aligned with rise_mark.
    edges = 0;
    drive(1, 0, 1, 1, 4);
    for (int c = 0; c < 10; c++) begin
      step("loop");
      start = 1'b0;
      check_bit("loop_align", edge_det, rise_mark);
      if (edge_det) edges++;
    end
    vectors++;
    if (edges != 4) begin
      miscompares++;
      $display("FAIL loop_count: got %0d edges, expected 4", edges);
    end

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 24) == 0),
            int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
            int'($urandom_range(0, 4)));
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
